// File: rtl/button_scan_pkg.sv
// Shared types and defaults for the button scan/debounce controller.
package button_scan_pkg;

    localparam int unsigned N_BTN_DEF      = 8;
    localparam int unsigned STABLE_CNT_DEF = 127;
    localparam int unsigned CNT_W          = 8;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        EMIT     = 2'd2
    } state_t;

endpackage

// File: rtl/button_sync.sv
// N-bit two-flop synchronizer for asynchronous button levels, reset to 0.
module button_sync
    import button_scan_pkg::*;
#(
    parameter int unsigned WIDTH = N_BTN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_scan_ctrl.sv
// Time-multiplexed button debouncer: one shared counter walks all buttons and
// emits a valid/ready event per accepted level change. BUTTON_SCAN_SYNC_EN adds an input synchronizer.
module button_scan_ctrl
    import button_scan_pkg::*;
#(
    parameter int unsigned N_BTN      = N_BTN_DEF,
    parameter int unsigned STABLE_CNT = STABLE_CNT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         dirty,
    output logic [N_BTN-1:0]         clean,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic                     evt_press,
    output logic                     busy
);

    localparam int unsigned IDX_W = $clog2(N_BTN);

    logic [N_BTN-1:0] sample;

`ifdef BUTTON_SCAN_SYNC_EN
    button_sync #(
        .WIDTH (N_BTN)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (dirty),
        .q   (sample)
    );
`else
    assign sample = dirty;
`endif

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_sat;
    logic             lvl;
    logic             cur;

    assign cur     = sample[idx];
    assign idx_nxt = (idx == IDX_W'(N_BTN - 1)) ? '0 : idx + IDX_W'(1);
    // Counter never wraps; it holds at all-ones.
    assign cnt_sat = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCAN;
            idx       <= '0;
            cnt       <= '0;
            lvl       <= 1'b0;
            clean     <= '0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_press <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                SCAN: begin
                    if (cur != clean[idx]) begin
                        lvl   <= cur;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= DEBOUNCE;
                    end else begin
                        idx <= idx_nxt;
                    end
                end
                DEBOUNCE: begin
                    if (cur != lvl) begin
                        busy  <= 1'b0;
                        idx   <= idx_nxt;
                        state <= SCAN;
                    end else if (cnt == CNT_W'(STABLE_CNT)) begin
                        // Level held long enough: commit and publish the event.
                        clean[idx] <= lvl;
                        evt_id     <= idx;
                        evt_press  <= lvl;
                        evt_valid  <= 1'b1;
                        state      <= EMIT;
                    end else begin
                        cnt <= cnt_sat;
                    end
                end
                EMIT: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        busy      <= 1'b0;
                        idx       <= idx_nxt;
                        state     <= SCAN;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    evt_valid <= 1'b0;
                    state     <= SCAN;
                end
            endcase
        end
    end

endmodule
